// File: rtl/gobou_ctrl_mac_pkg.sv
// Shared gobou MAC-controller constants: drain latency and accumulate-count width.
package gobou_ctrl_mac_pkg;

    localparam int unsigned GOBOU_MAC_DELAY = 3;
    localparam int unsigned LWIDTH          = 4;

endpackage

// File: rtl/ctrl_bus.sv
// Three-wire start/valid/stop control stream between controllers.
interface ctrl_bus;

    logic start;
    logic valid;
    logic stop;

    modport master (output start, output valid, output stop);
    modport slave  (input start, input valid, input stop);

endinterface

// File: rtl/gobou_ctrl_mac.sv
// MAC pass sequencer: clears, accumulates and biases the per-core accumulators,
// then signals result-ready once the MAC pipeline has drained.
module gobou_ctrl_mac
    import gobou_ctrl_mac_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    ctrl_bus.slave            in_ctrl,
    ctrl_bus.master           out_ctrl,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              bias_en,
    output logic [LWIDTH-1:0] acc_cnt,
    output logic              busy,
    output logic              err
);

    localparam int unsigned DRAIN_W = $clog2(GOBOU_MAC_DELAY + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(GOBOU_MAC_DELAY - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_PRE  = DRAIN_LAST - DRAIN_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               out_start;
    logic               out_valid;
    logic               out_stop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            drain_cnt <= '0;
            acc_cnt   <= '0;
            err       <= 1'b0;
            mac_clr   <= 1'b0;
            mac_en    <= 1'b0;
            bias_en   <= 1'b0;
            out_start <= 1'b0;
            out_valid <= 1'b0;
            out_stop  <= 1'b0;
        end else begin
            mac_clr   <= 1'b0;
            mac_en    <= 1'b0;
            bias_en   <= 1'b0;
            out_start <= 1'b0;
            out_valid <= 1'b0;
            out_stop  <= 1'b0;
            case (state)
                S_IDLE: begin
                    // out_stop high marks the return-to-idle cycle, where start is refused
                    if (in_ctrl.start && !out_stop) begin
                        state   <= S_ACC;
                        acc_cnt <= '0;
                        mac_clr <= 1'b1;
                        err     <= in_ctrl.valid | in_ctrl.stop;
                    end else if (in_ctrl.start || in_ctrl.valid || in_ctrl.stop) begin
                        err <= 1'b1;
                    end
                end
                S_ACC: begin
                    if (in_ctrl.start) err <= 1'b1;
                    if (in_ctrl.stop) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                        bias_en   <= 1'b1;
                        if (GOBOU_MAC_DELAY == 1) out_start <= 1'b1;
                    end else if (in_ctrl.valid) begin
                        mac_en <= 1'b1;
                        if (acc_cnt != '1) acc_cnt <= acc_cnt + LWIDTH'(1);
                    end
                end
                S_DRAIN: begin
                    if (in_ctrl.start) err <= 1'b1;
                    if (drain_cnt == DRAIN_LAST) begin
                        state     <= S_IDLE;
                        drain_cnt <= '0;
                        out_valid <= 1'b1;
                        out_stop  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                        // Registered, so raise it one cycle ahead of the last drain cycle
                        if (drain_cnt == DRAIN_PRE) out_start <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    drain_cnt <= '0;
                end
            endcase
        end
    end

    assign busy           = (state == S_ACC) || (state == S_DRAIN);
    assign out_ctrl.start = out_start;
    assign out_ctrl.valid = out_valid;
    assign out_ctrl.stop  = out_stop;

endmodule

// File: doc/gobou_ctrl_mac.md
GOBOU_CTRL_MAC -- requirements
Module: gobou_ctrl_mac

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous active-high reset.
REQ-004 Port: in_ctrl  ctrl_bus.slave  start/valid/stop, 1 bit each  command stream from the core controller; stop coincides with the final (bias) valid.
REQ-005 Port: out_ctrl  ctrl_bus.master  start/valid/stop, 1 bit each  result-ready stream back to the core controller.
REQ-006 Port: mac_clr  output  1  clear all per-core accumulators.
REQ-007 Port: mac_en  output  1  accumulate current image word times weight.
REQ-008 Port: bias_en  output  1  add the bias register into the accumulator.
REQ-009 Port: acc_cnt  output  LWIDTH  number of weight words accumulated in the current pass.
REQ-010 Port: busy  output  1  high in S_ACC and S_DRAIN.
REQ-011 Port: err  output  1  sticky protocol-violation flag.

Function
REQ-012 FSM states SHALL be S_IDLE, S_ACC and S_DRAIN; an illegal encoding SHALL go to S_IDLE.
REQ-013 S_IDLE -> S_ACC on in_ctrl.start; on that cycle acc_cnt <= 0 and err <= 0, and mac_clr SHALL pulse high for exactly one cycle on the next cycle (latency 1).
REQ-014 In S_ACC, each in_ctrl.valid with stop low SHALL produce a one-cycle mac_en exactly 1 cycle later and increment acc_cnt, saturating at 2^LWIDTH-1.
REQ-015 In S_ACC, in_ctrl.stop (with or without valid) SHALL produce bias_en 1 cycle later, SHALL NOT assert mac_en or increment acc_cnt, and SHALL move to S_DRAIN.
REQ-016 S_DRAIN SHALL last exactly GOBOU_MAC_DELAY cycles, counted by a drain counter starting at 0.
REQ-017 On the last S_DRAIN cycle, out_ctrl.start SHALL pulse high for one cycle; on the following cycle, out_ctrl.valid and out_ctrl.stop SHALL pulse high together for one cycle, and the state SHALL return to S_IDLE.
REQ-018 The total latency from in_ctrl.stop to out_ctrl.start SHALL be GOBOU_MAC_DELAY cycles.
REQ-019 A start received in S_ACC or S_DRAIN SHALL be ignored and SHALL set err.
REQ-020 valid or stop received in S_IDLE SHALL be ignored and SHALL set err.
REQ-021 If start and stop arrive together in S_IDLE, start SHALL win, stop SHALL be ignored, and err SHALL be set.
REQ-022 A start arriving on the same cycle that the FSM returns to S_IDLE SHALL be ignored and SHALL set err.
REQ-023 mac_clr, mac_en, bias_en and all out_ctrl bits SHALL be registered outputs that are never high simultaneously with each other, except out_ctrl.valid together with out_ctrl.stop.

Reset
REQ-024 While rst is high, the state SHALL be S_IDLE and every output SHALL be 0 (mac_clr, mac_en, bias_en, acc_cnt, busy, err, out_ctrl.start/valid/stop), and the drain counter SHALL be 0.
REQ-025 Reset asserted mid-pass SHALL abort the pass; no out_ctrl pulse SHALL follow the deassertion of reset.

Structure
REQ-026 GOBOU_MAC_DELAY (default 3, minimum 1) and LWIDTH SHALL live in the shared gobou package/header; the state enum SHALL be local.
REQ-027 No sub-module is required; the drain timer SHALL be an in-module counter of width clog2(GOBOU_MAC_DELAY+1).

Verification
REQ-028 Normal pass: start, 4 valids, then valid+stop -> mac_clr 1 cycle after start, 4 mac_en pulses, 1 bias_en, acc_cnt=4, out_ctrl.start 3 cycles after stop, then valid+stop 1 cycle later.
REQ-029 Gapped valids: start, valid pattern 1,0,1,1,0,1, then stop -> 4 mac_en pulses spaced as the input pattern (each delayed 1 cycle), acc_cnt=4.
REQ-030 Protocol errors: valid in S_IDLE -> no mac_en and err=1; the next start -> err=0; a second start mid-S_ACC -> err=1 and the pass completes unaffected.
REQ-031 Back-to-back passes: new start 2 cycles after out_ctrl.stop -> second pass has independent acc_cnt and mac_clr; a start on the return-to-IDLE cycle -> ignored and err=1.
REQ-032 Reset mid-S_DRAIN: rst for 1 cycle at drain cycle 1 -> all outputs 0 and no out_ctrl.start for 10 cycles afterwards.
REQ-033 Saturation: with LWIDTH=4, 20 valids -> acc_cnt holds at 15.
